pixel_streamer: RTL
===================

Name: pixel_streamer

Overview:
- Transmitter that feeds the CNN window generator.
- Holds one frame of pixels in an internal buffer that is loaded over a simple write port.
- On `start`, replays the frame in raster order as a valid/ready pixel stream, with optional zero-padding border and row/frame markers.
- Sits between the frame loader (host/testbench/DMA) and the window/convolution pipeline.

Parameters:
- WORD_SIZE, 8, pixel width in bits
- ROW_SIZE, 10, pixels per image row (width)
- COL_SIZE, 10, image rows (height)
- PAD, 1, zero border width on each side (0 = no padding)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- wr_en  input  1  write strobe for frame buffer
- wr_addr  input  $clog2(ROW_SIZE*COL_SIZE)  raster address (row*ROW_SIZE+col)
- wr_data  input  WORD_SIZE  pixel to store
- start  input  1  pulse: begin streaming frame
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse after last pixel transferred
- out_pixel  output  WORD_SIZE  streamed pixel
- out_valid  output  1  out_pixel valid
- out_ready  input  1  downstream accepts
- out_sof  output  1  first pixel of frame
- out_eol  output  1  last pixel of a row
- out_eof  output  1  last pixel of frame

Behaviour:
- Output frame size is OW = ROW_SIZE+2*PAD by OH = COL_SIZE+2*PAD.
- Position (x,y) with PAD ≤ x < PAD+ROW_SIZE and PAD ≤ y < PAD+COL_SIZE emits buffer[(y-PAD)*ROW_SIZE + (x-PAD)]. All other positions emit 0.
- Reset (rst=0, asynchronous):
  - State is IDLE; x and y counters are 0.
  - busy, done, out_valid, out_sof, out_eol and out_eof are 0; out_pixel is 0.
  - Frame buffer contents are not reset.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - wr_en=1 writes wr_data to buffer[wr_addr] at the clock edge.
  - wr_addr ≥ ROW_SIZE*COL_SIZE is ignored.
  - start=1 moves to STREAM, sets busy=1 and clears the counters.
  - start and wr_en in the same cycle: the write completes and start is accepted.
- STREAM:
  - All outputs are registered. The first out_valid=1 appears on the cycle after start is sampled, so latency is 1 cycle.
  - A transfer occurs on any edge with out_valid & out_ready.
  - On a transfer, the next pixel and its markers load on the same edge, so ready held at 1 gives one pixel per cycle with no bubbles.
  - Without a transfer, out_pixel, out_valid and all markers hold stable. out_valid never drops before the transfer.
  - Markers are asserted together with their pixel:
    - out_sof at (0,0)
    - out_eol at x=OW-1
    - out_eof at (OW-1, OH-1), coincident with out_eol
  - Counters advance x, wrapping at OW to 0 and incrementing y.
  - On transfer of the eof pixel: out_valid→0 and state → DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next cycle: done=0, busy=0, state → IDLE.
- While busy=1:
  - start is ignored.
  - wr_en is ignored, so the buffer is not modified mid-frame.
- Reset asserted mid-frame aborts immediately to the reset values above. No done pulse is produced. A subsequent start streams from (0,0).
- Degenerate sizing:
  - ROW_SIZE ≥ 1 and COL_SIZE ≥ 1 are required. PAD=0 is legal.
  - A 1-pixel-wide output row asserts out_sof and out_eol on the same pixel.

Test Plan:
- PAD=0, write buffer[i]=i+1 for i=0..99, start, out_ready=1 → 100 consecutive pixels 1..100:
  - out_sof on pixel 1; out_eol on 10,20,…,100; out_eof on 100.
  - done pulses 1 cycle after the last transfer; busy low 1 cycle after that.
- PAD=1, same buffer, ready=1 → 144 pixels:
  - Row 0 is twelve 0s. Row 1 is 0,1..10,0. Row 11 is twelve 0s.
  - out_eol every 12th pixel; out_eof on pixel 144.
- PAD=0, out_ready toggling 1,0,0,1,… → every pixel and marker held stable while ready=0. Sequence and count are identical to the ready=1 case; no duplicates or drops.
- During STREAM, pulse start and write wr_addr=0, wr_data=0xFF → streaming is not restarted. Pixel 1 of the next frame is still 1.
- Write wr_addr=100 (out of range) with 0xAA, then stream → no pixel equals 0xAA and no other buffer location changes.
- Assert rst=0 asynchronously after 37 transfers → all outputs 0 immediately with no done pulse. Release reset, start → the stream restarts at pixel 1 with out_sof and the buffer is intact.

Source files
------------

// File: rtl/pixel_streamer.sv
// rtl/pixel_streamer.sv - frame buffer replayed as a padded raster valid/ready pixel stream
module pixel_streamer #(
    parameter int WORD_SIZE = 8,
    parameter int ROW_SIZE  = 10,
    parameter int COL_SIZE  = 10,
    parameter int PAD       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [((ROW_SIZE*COL_SIZE > 1) ? $clog2(ROW_SIZE*COL_SIZE) : 1)-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] out_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof
);
    localparam int N  = ROW_SIZE * COL_SIZE;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = ROW_SIZE + 2 * PAD;
    localparam int OH = COL_SIZE + 2 * PAD;
    localparam int XW = $clog2(OW + 1);
    localparam int YW = $clog2(OH + 1);

    localparam logic [XW-1:0] X_LO   = XW'(PAD);
    localparam logic [XW-1:0] X_HI   = XW'(PAD + ROW_SIZE);
    localparam logic [XW-1:0] X_LAST = XW'(OW - 1);
    localparam logic [YW-1:0] Y_LO   = YW'(PAD);
    localparam logic [YW-1:0] Y_HI   = YW'(PAD + COL_SIZE);
    localparam logic [YW-1:0] Y_LAST = YW'(OH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t               state;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [WORD_SIZE-1:0] mem [N];

    logic [XW-1:0]        nx, rx;
    logic [YW-1:0]        ny, ry;
    logic [AW-1:0]        rd_addr;
    logic                 in_img, wr_ok;
    logic                 n_sof, n_eol, n_eof;
    logic [WORD_SIZE-1:0] rd_pix;

    // Everything below describes the pixel that loads on the next accepted edge:
    // (0,0) when starting from IDLE, otherwise the raster successor of (x,y).
    always_comb begin
        nx = '0;
        ny = '0;
        if (state == STREAM) begin
            if (x == X_LAST) begin
                nx = '0;
                ny = y + 1'b1;
            end else begin
                nx = x + 1'b1;
                ny = y;
            end
        end
        in_img  = (nx >= X_LO) && (nx < X_HI) && (ny >= Y_LO) && (ny < Y_HI);
        rx      = nx - X_LO;
        ry      = ny - Y_LO;
        rd_addr = AW'(ry) * AW'(ROW_SIZE) + AW'(rx);
        wr_ok   = wr_en && (state == IDLE) && (32'(wr_addr) < N);
        n_sof   = (nx == '0) && (ny == '0);
        n_eol   = (nx == X_LAST);
        n_eof   = n_eol && (ny == Y_LAST);
        rd_pix  = '0;
        // A write landing with start still has to show up in the first pixel.
        if (in_img) begin
            if (wr_ok && (wr_addr == rd_addr))
                rd_pix = wr_data;
            else
                rd_pix = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_pixel <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= STREAM;
                        busy      <= 1'b1;
                        x         <= '0;
                        y         <= '0;
                        out_valid <= 1'b1;
                        out_pixel <= rd_pix;
                        out_sof   <= n_sof;
                        out_eol   <= n_eol;
                        out_eof   <= n_eof;
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        if (out_eof) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            x         <= '0;
                            y         <= '0;
                            out_valid <= 1'b0;
                            out_pixel <= '0;
                            out_sof   <= 1'b0;
                            out_eol   <= 1'b0;
                            out_eof   <= 1'b0;
                        end else begin
                            x         <= nx;
                            y         <= ny;
                            out_pixel <= rd_pix;
                            out_sof   <= n_sof;
                            out_eol   <= n_eol;
                            out_eof   <= n_eof;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
